// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
// The master issues requests and receives responses; the slave is the controller.
interface data_memory_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data memory controller: byte/half/word loads and stores against a DEPTH-word
// array with a fixed read latency of RD_LAT cycles and a one-cycle store response.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return an
// error instead of having their low address bits silently cleared.
module data_memory_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 2
) (
    input logic               clk,
    input logic               rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rdy_q;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q, off_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              req_err;
    logic [1:0]        off_c;
    logic [3:0]        be_c;
    logic [AW-1:0]     idx_c;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_ext;

    assign accept = (state_q == IDLE) && rdy_q && bus.req_valid;

    // Decode the live request: error conditions, lane offset and byte enables.
    always_comb begin
        logic oor;
        logic mis;
        oor   = |bus.req_addr[31:AW+2];
        mis   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`endif
        off_c = 2'b00;
        be_c  = 4'b1111;
        case (bus.req_size)
            2'b00: begin
                off_c = bus.req_addr[1:0];
                be_c  = 4'b0001 << off_c;
            end
            2'b01: begin
                // Without the trap, addr[0] is simply dropped here.
                off_c = {bus.req_addr[1], 1'b0};
                be_c  = 4'b0011 << off_c;
            end
            default: begin
                off_c = 2'b00;
                be_c  = 4'b1111;
            end
        endcase
        req_err  = oor || (bus.req_size == 2'b11) || mis;
        idx_c    = bus.req_addr[AW+1:2];
        wdata_sh = bus.req_wdata << {off_c, 3'b000};
    end

    // Array write: selected lanes committed at the accept edge; no reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // State, latency counter, ready enable and captured request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            if (accept) begin
                we_q   <= bus.req_we;
                uns_q  <= bus.req_unsigned;
                err_q  <= req_err;
                size_q <= bus.req_size;
                off_q  <= off_c;
                idx_q  <= idx_c;
            end
        end
    end

    // Next-state logic; the WAIT exit fires as the counter steps down to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_we || (RD_LAT == 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load data path: array read at the response cycle, lane shift and extension.
    always_comb begin
        rd_sh  = mem_q[idx_q] >> {off_q, 3'b000};
        rd_ext = rd_sh;
        case (size_q)
            2'b00:   rd_ext = uns_q ? {{(DATA_W-8){1'b0}}, rd_sh[7:0]}
                                    : {{(DATA_W-8){rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   rd_ext = uns_q ? {{(DATA_W-16){1'b0}}, rd_sh[15:0]}
                                    : {{(DATA_W-16){rd_sh[15]}}, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE) && rdy_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? rd_ext : '0;

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning data width in bits; only 32 is supported.
REQ-002 The block SHALL take parameter DEPTH, default 256, meaning number of DATA_W words; must be a power of two.
REQ-003 The block SHALL take parameter RD_LAT, default 2, meaning read latency in cycles; legal range 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 The block SHALL have port req_unsigned, input, 1 bit: 1 means zero-extend loads, 0 means sign-extend.
REQ-012 The block SHALL have port req_wdata, input, DATA_W bits: store data, right-aligned.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: single-cycle response pulse.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: load result; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the request failed; valid only with rsp_valid.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 The block SHALL drive req_ready high only in IDLE.
REQ-018 The block SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-019 On accept, the block SHALL capture the request fields and then ignore them until it returns to IDLE.
REQ-020 On store accept, the block SHALL commit byte lanes to the array at that same edge, then go to RESP.
REQ-021 A store SHALL produce rsp_valid exactly 1 cycle after the accept edge.
REQ-022 On load accept, the block SHALL go to WAIT, load a counter with RD_LAT-1, and decrement it each cycle.
REQ-023 A load SHALL go to RESP when the counter reaches 0, producing rsp_valid exactly RD_LAT cycles after the accept edge; if RD_LAT=1, the load SHALL go directly to RESP.
REQ-024 From RESP, the block SHALL always return to IDLE on the next edge; there is no response backpressure, and a new request can be accepted every RD_LAT+1 cycles for loads and every 2 cycles for stores.
REQ-025 The word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-026 Any set bit in req_addr[31:log2(DEPTH)+2] SHALL give an out-of-range result: rsp_err=1, no array write, rsp_rdata=0.
REQ-027 Lane selection SHALL be: byte lane at addr[1:0]; half at bytes {addr[1],0} and {addr[1],1}; word uses all 4 lanes.
REQ-028 Stores SHALL write only the selected lanes from req_wdata low bits, leaving other lanes unchanged.
REQ-029 Loads SHALL shift the selected lanes to bit 0, then sign- or zero-extend them per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-030 req_size=11 SHALL give rsp_err=1, no write, and rsp_rdata=0.
REQ-031 Array read data SHALL be sampled at the response cycle, so a load SHALL see every store accepted before it.

Reset
REQ-032 While rst_n is low, the block SHALL immediately force state to IDLE, the counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_err to 0, and SHALL drive req_ready low.
REQ-033 req_ready SHALL go high on the first edge after rst_n rises.
REQ-034 Reset during WAIT or RESP SHALL discard the pending response; no rsp_valid SHALL follow.
REQ-035 A store already committed SHALL persist through reset.
REQ-036 Array contents SHALL NOT be reset.

Configuration
REQ-037 With macro DMEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL give rsp_err=1, no write, and rsp_rdata=0.
REQ-038 With DMEM_MISALIGN_TRAP_EN undefined, the block SHALL silently clear the offending low address bits (half: addr[0]; word: addr[1:0]) and complete the access normally with rsp_err=0.
REQ-039 Latency SHALL be identical in both configurations.

Verification
REQ-040 Word store then load: store 0xDEADBEEF at 0x10, then load a word from 0x10 with RD_LAT=2 -> store rsp_valid 1 cycle after accept; load rsp_valid 2 cycles after accept with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-041 Byte store and extended loads: byte store 0x80 at 0x13, then signed byte load from 0x13 -> 0xFFFFFF80; unsigned byte load from 0x13 -> 0x00000080; word load from 0x10 -> 0x80ADBEEF.
REQ-042 Half access: half store 0x1234 at 0x22, then unsigned half load from 0x22 -> 0x00001234; word load from 0x20 -> bits[31:16]=0x1234, bits[15:0] unchanged.
REQ-043 Misalignment: word load from 0x11 -> with macro, rsp_err=1 and rsp_rdata=0; without macro, returns the word at 0x10 with rsp_err=0.
REQ-044 Range and reserved: store to 0x400 with DEPTH=256 -> rsp_err=1 and word 0 unchanged; req_size=11 -> rsp_err=1.
REQ-045 Reset mid-read: assert rst_n low 1 cycle after a load accept with RD_LAT=4 -> no rsp_valid, req_ready low during reset, req_ready high 1 cycle after rst_n rises.
